bf16_reduce_sum: RTL and testbench
==================================

Name: bf16_reduce_sum

Overview:
- Parametrised successor to the fixed four-operand bf16 add block: sums N_OPS bf16 operands as a balanced pairwise tree, ((x0+x1)+(x2+x3))+...
- Uses one shared adder_bf16 instance, time-multiplexed across all N_OPS-1 additions.
- Sits between the co-processor operand fetch and its result writeback.
- Uses the same STB/BUSY handshake on input, on the internal adder, and on output.

Parameters:
- N_OPS, 4, number of operands; power of two, 2..16; other values are rejected at elaboration with $error.
- LOG2_N, $clog2(N_OPS), derived and not overridable; number of tree levels.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- operands  input  16*N_OPS  packed bf16 operands; operand i is operands[16*i+15:16*i].
- in_STB  input  1  operand vector valid.
- in_BUSY  output  1  block is occupied; operands are not accepted while high.
- result  output  16  bf16 tree sum.
- out_STB  output  1  result valid.
- out_module_BUSY  input  1  downstream consumer not ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - in_BUSY=0, out_STB=0, result=16'h0000.
  - Adder input STB=0, adder output_module_BUSY=1, state=IDLE.
  - The operand buffer is not cleared.
  - Reset asserted mid-operation aborts that operation. No out_STB is produced for it. The first in_STB after reset release is accepted normally.
- Operand buffer:
  - buf[0..N_OPS-1], 16 bits each.
  - Level counter lvl, 0..LOG2_N-1; pair index p.
  - Pairs per level = N_OPS>>(lvl+1).
- IDLE:
  - in_BUSY=0.
  - On in_STB=1: latch all operands into buf, set in_BUSY=1, set lvl=0, p=0, go to ISSUE. Capture takes exactly one cycle.
- ISSUE:
  - Drive adder input_a=buf[2p], input_b=buf[2p+1], and assert adder STB.
  - When STB=1 and adder_BUSY=1 in the same cycle: drop STB, drive adder output_module_BUSY=0, go to WAIT.
- WAIT:
  - When adder_output_STB=1 and output_module_BUSY=0: write output_sum into buf[p] and raise output_module_BUSY=1.
  - If p is the last pair of the level: p=0, lvl=lvl+1. Otherwise p=p+1.
  - If lvl was LOG2_N-1 (final addition), go to DONE. Otherwise go to ISSUE.
- In-place overwrite is safe:
  - buf[p] is written only after buf[2p] and buf[2p+1] have been consumed.
  - p <= 2p always holds.
- DONE:
  - result=buf[0], out_STB=1.
  - When out_STB=1 and out_module_BUSY=0: out_STB=0, go to IDLE. in_BUSY falls in that same cycle.
  - result holds its value until the next DONE.
- in_STB while in_BUSY=1 is ignored; no queuing.
- Arithmetic:
  - Exactly N_OPS-1 adder_bf16 operations per vector, in fixed tree order. Results are bit-exact with that order, not with a serial sum.
  - Rounding, NaN, Inf and denormal handling are exactly those of adder_bf16; this block does no arithmetic of its own.
- Latency:
  - 1 capture cycle, plus the sum over all additions of (issue + adder latency + 1 writeback cycle), plus 1 cycle to present the result.
  - The bench measures it from in_STB to out_STB and checks it is constant for a fixed adder latency.
- N_OPS=2: single level, one addition, then straight to DONE.

Optional Feature:
- Macro: BF16_REDUCE_ACC_EN.
- Defined:
  - Adds input port acc_clr (1 bit) and a 16-bit accumulator register acc, reset to 16'h0000.
  - After the tree finishes, one extra addition is performed: acc + buf[0], in state ACC_ISSUE then ACC_WAIT.
  - Its sum is written to both acc and result. Latency grows by one addition.
  - acc_clr is sampled with in_STB at capture. If acc_clr=1, acc is treated as 16'h0000 for this vector, and the stored acc becomes this vector's sum.
- Undefined: no acc_clr port, no accumulator; result is the plain tree sum.

Test Plan:
- N_OPS=4, operands {3F80,4000,4040,4080} (1,2,3,4), out_module_BUSY=0 -> out_STB=1 once, result=4120 (10.0), adder used exactly 3 times.
- N_OPS=4, {3F80,BF80,4000,C000} -> result=0000, i.e. (1-1)+(2-2)=+0.
- N_OPS=8, all eight operands 3F80 -> result=4100 (8.0), 7 adder handshakes; hold out_module_BUSY=1 for 5 cycles -> out_STB and result stable, in_BUSY=1, and a second in_STB during this window is ignored.
- N_OPS=4, assert rst=0 during the second addition's WAIT -> in_BUSY=0 and out_STB=0 immediately (asynchronous); next vector {4000,4000,4000,4000} -> result=4100 (8.0).
- BF16_REDUCE_ACC_EN, N_OPS=4: vector {3F80,3F80,3F80,3F80} with acc_clr=1 -> result=4080 (4.0); same vector with acc_clr=0 -> result=4100 (8.0); then acc_clr=1 -> result=4080.
- N_OPS=2: {3F00,3F00} -> result=3F80 (1.0), exactly one adder handshake.

Source files
------------

// File: rtl/bf16_reduce_sum.sv
// bf16_reduce_sum: sums N_OPS bf16 operands as a balanced pairwise tree
// ((x0+x1)+(x2+x3))+... using one shared, time-multiplexed adder_bf16.
// Optional feature macro: BF16_REDUCE_ACC_EN adds a running accumulator
// (port acc_clr) and one extra addition acc + tree_sum per vector.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   operands        packed operands, operand i at [16*i+15:16*i]
//   in_STB/in_BUSY  operand vector valid / block occupied
//   acc_clr         (BF16_REDUCE_ACC_EN only) treat accumulator as zero
//   result/out_STB  registered tree sum / result valid
//   out_module_BUSY downstream not ready

// adder_bf16: single-operation bf16 adder with STB/BUSY handshakes.
// Round to nearest even, denormals flushed to zero, quiet NaN 16'h7FC0.
// Ports: i_a/i_b/i_stb/o_busy input side, o_sum/o_stb/i_out_busy output side.
module adder_bf16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_stb,
    output logic        o_busy,
    output logic [15:0] o_sum,
    output logic        o_stb,
    input  logic        i_out_busy
);
    typedef enum logic [1:0] {A_IDLE, A_CALC, A_OUT} add_state_t;

    add_state_t  r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;

    function automatic logic [3:0] lzc11(input logic [10:0] v);
        logic [3:0] n;
        logic       found;
        n     = 4'd0;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 4'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic               sl, ss;
        logic [7:0]         el, es, d;
        logic [10:0]        ml, ms, mshift, mn;
        logic [21:0]        wide;
        logic [11:0]        sum;
        logic [8:0]         mr;
        logic [3:0]         lz;
        logic signed [9:0]  e;
        logic               rup;
        logic [15:0]        res;
        res = 16'h0000;
        if ((a[14:7] == 8'hFF && a[6:0] != 7'h00) || (b[14:7] == 8'hFF && b[6:0] != 7'h00)) begin
            res = 16'h7FC0;
        end else if (a[14:7] == 8'hFF && b[14:7] == 8'hFF) begin
            res = (a[15] == b[15]) ? a : 16'h7FC0;
        end else if (a[14:7] == 8'hFF) begin
            res = a;
        end else if (b[14:7] == 8'hFF) begin
            res = b;
        end else if (a[14:7] == 8'h00 && b[14:7] == 8'h00) begin
            res = {a[15] & b[15], 15'h0000};
        end else if (a[14:7] == 8'h00) begin
            res = b;
        end else if (b[14:7] == 8'h00) begin
            res = a;
        end else begin
            // Larger magnitude first; mantissa = hidden.7 bits.guard.round.sticky
            if (a[14:0] >= b[14:0]) begin
                {sl, el, ml} = {a[15], a[14:7], 1'b1, a[6:0], 3'b000};
                {ss, es, ms} = {b[15], b[14:7], 1'b1, b[6:0], 3'b000};
            end else begin
                {sl, el, ml} = {b[15], b[14:7], 1'b1, b[6:0], 3'b000};
                {ss, es, ms} = {a[15], a[14:7], 1'b1, a[6:0], 3'b000};
            end
            d      = el - es;
            wide   = {ms, 11'h000} >> d;
            mshift = wide[21:11] | {10'h000, |wide[10:0]};
            e      = $signed({2'b00, el});
            if (sl == ss) sum = {1'b0, ml} + {1'b0, mshift};
            else          sum = {1'b0, ml} - {1'b0, mshift};
            if (sum == 12'h000) begin
                res = 16'h0000;
            end else begin
                if (sum[11]) begin
                    mn = sum[11:1] | {10'h000, sum[0]};
                    e  = e + 10'sd1;
                end else begin
                    lz = lzc11(sum[10:0]);
                    mn = sum[10:0] << lz;
                    e  = e - $signed({6'b000000, lz});
                end
                rup = mn[2] & (mn[1] | mn[0] | mn[3]);
                mr  = {1'b0, mn[10:3]} + {8'h00, rup};
                if (mr[8]) begin
                    mr = mr >> 1;
                    e  = e + 10'sd1;
                end
                if (e <= 10'sd0)        res = {sl, 15'h0000};
                else if (e >= 10'sd255) res = {sl, 8'hFF, 7'h00};
                else                    res = {sl, e[7:0], mr[6:0]};
            end
        end
        return res;
    endfunction

    // Adder handshake FSM: accept, compute one cycle, hold sum until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= A_IDLE;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            o_busy  <= 1'b0;
            o_sum   <= 16'h0000;
            o_stb   <= 1'b0;
        end else begin
            case (r_state)
                A_IDLE: if (i_stb && !o_busy) begin
                    r_a     <= i_a;
                    r_b     <= i_b;
                    o_busy  <= 1'b1;
                    r_state <= A_CALC;
                end
                A_CALC: begin
                    o_sum   <= bf16_add(r_a, r_b);
                    o_stb   <= 1'b1;
                    r_state <= A_OUT;
                end
                A_OUT: if (o_stb && !i_out_busy) begin
                    o_stb   <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= A_IDLE;
                end
                default: r_state <= A_IDLE;
            endcase
        end
    end
endmodule

module bf16_reduce_sum #(
    parameter int N_OPS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*N_OPS-1:0]  operands,
    input  logic                 in_STB,
`ifdef BF16_REDUCE_ACC_EN
    input  logic                 acc_clr,
`endif
    output logic                 in_BUSY,
    output logic [15:0]          result,
    output logic                 out_STB,
    input  logic                 out_module_BUSY
);
    localparam int LOG2_N = $clog2(N_OPS);
    localparam int N_W    = LOG2_N + 1;

    if ((N_OPS < 2) || (N_OPS > 16) || ((N_OPS & (N_OPS - 1)) != 0)) begin : g_bad_n_ops
        $error("bf16_reduce_sum: N_OPS must be a power of two in 2..16");
    end

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACC_ISSUE, S_ACC_WAIT, S_DONE} state_t;

    state_t            r_state;
    logic [15:0]       r_buf [N_OPS];
    logic [LOG2_N-1:0] r_lvl;
    logic [LOG2_N-1:0] r_p;
    logic              r_add_stb;
    logic              r_add_obusy;
    logic [15:0]       w_add_a;
    logic [15:0]       w_add_b;
    logic              w_add_busy;
    logic [15:0]       w_add_sum;
    logic              w_add_ostb;
    logic [LOG2_N-1:0] w_idx_a;
    logic [LOG2_N-1:0] w_idx_b;
    logic [N_W-1:0]    w_pairs;
    logic              w_last_pair;
    logic              w_final;
    logic              w_capture;
    logic              w_write;
`ifdef BF16_REDUCE_ACC_EN
    logic [15:0]       r_acc;
    logic              r_acc_clr;
`endif

    // p < pairs-per-level, so 2p never overflows the index width
    assign w_idx_a     = r_p << 1;
    assign w_idx_b     = w_idx_a + LOG2_N'(1);
    assign w_pairs     = N_W'(N_OPS >> (int'(r_lvl) + 1));
    assign w_last_pair = (({1'b0, r_p} + N_W'(1)) == w_pairs);
    assign w_final     = (r_lvl == LOG2_N'(LOG2_N - 1));
    assign w_capture   = (r_state == S_IDLE) && in_STB;
    assign w_write     = (r_state == S_WAIT) && w_add_ostb && !r_add_obusy;

    // Adder operand select: current tree pair, or accumulator step
    always_comb begin
        w_add_a = r_buf[w_idx_a];
        w_add_b = r_buf[w_idx_b];
`ifdef BF16_REDUCE_ACC_EN
        if (r_state == S_ACC_ISSUE) begin
            w_add_a = r_acc_clr ? 16'h0000 : r_acc;
            w_add_b = r_buf[0];
        end else begin
            w_add_a = r_buf[w_idx_a];
            w_add_b = r_buf[w_idx_b];
        end
`endif
    end

    adder_bf16 u_add (
        .clk        (clk),
        .rst        (rst),
        .i_a        (w_add_a),
        .i_b        (w_add_b),
        .i_stb      (r_add_stb),
        .o_busy     (w_add_busy),
        .o_sum      (w_add_sum),
        .o_stb      (w_add_ostb),
        .i_out_busy (r_add_obusy)
    );

    // Operand buffer: not reset; partial sums overwrite buf[p] in place (p <= 2p)
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < N_OPS; i++) r_buf[i] <= operands[16*i +: 16];
        end else if (w_write) begin
            r_buf[r_p] <= w_add_sum;
        end
    end

    // Control FSM: capture, issue/wait per tree addition, present result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            in_BUSY     <= 1'b0;
            out_STB     <= 1'b0;
            result      <= 16'h0000;
            r_add_stb   <= 1'b0;
            r_add_obusy <= 1'b1;
            r_lvl       <= '0;
            r_p         <= '0;
`ifdef BF16_REDUCE_ACC_EN
            r_acc       <= 16'h0000;
            r_acc_clr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_STB) begin
                    in_BUSY   <= 1'b1;
                    r_lvl     <= '0;
                    r_p       <= '0;
                    r_add_stb <= 1'b1;
                    r_state   <= S_ISSUE;
`ifdef BF16_REDUCE_ACC_EN
                    r_acc_clr <= acc_clr;
`endif
                end
                S_ISSUE, S_ACC_ISSUE: if (r_add_stb && w_add_busy) begin
                    r_add_stb   <= 1'b0;
                    r_add_obusy <= 1'b0;
                    r_state     <= (r_state == S_ISSUE) ? S_WAIT : S_ACC_WAIT;
                end
                S_WAIT: if (w_add_ostb && !r_add_obusy) begin
                    r_add_obusy <= 1'b1;
                    if (w_last_pair) begin
                        r_p   <= '0;
                        r_lvl <= r_lvl + LOG2_N'(1);
                    end else begin
                        r_p   <= r_p + LOG2_N'(1);
                    end
                    if (w_final) begin
`ifdef BF16_REDUCE_ACC_EN
                        r_add_stb <= 1'b1;
                        r_state   <= S_ACC_ISSUE;
`else
                        result    <= w_add_sum;
                        out_STB   <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end else begin
                        r_add_stb <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
`ifdef BF16_REDUCE_ACC_EN
                S_ACC_WAIT: if (w_add_ostb && !r_add_obusy) begin
                    r_add_obusy <= 1'b1;
                    r_acc       <= w_add_sum;
                    result      <= w_add_sum;
                    out_STB     <= 1'b1;
                    r_state     <= S_DONE;
                end
`endif
                S_DONE: if (out_STB && !out_module_BUSY) begin
                    out_STB <= 1'b0;
                    in_BUSY <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_reduce_sum.sv
// Self-checking bench for bf16_reduce_sum: three instances (N_OPS 4, 8, 2),
// scoreboard queues filled at stimulus and drained on each out_STB rising.
module tb_bf16_reduce_sum;
`ifdef BF16_REDUCE_ACC_EN
    localparam int ACC_ADD = 1;
`else
    localparam int ACC_ADD = 0;
`endif

    logic clk;
    logic rst;
    logic [63:0]  ops4;
    logic [127:0] ops8;
    logic [31:0]  ops2;
    logic stb4, stb8, stb2;
    logic clr4, clr8, clr2;
    logic busy4, busy8, busy2;
    logic ostb4, ostb8, ostb2;
    logic obusy4, obusy8, obusy2;
    logic [15:0] res4, res8, res2;

    logic [15:0] q4[$];
    logic [15:0] q8[$];
    logic [15:0] q2[$];
    int n_checks = 0;
    int n_errors = 0;
    int adds4 = 0, adds8 = 0, adds2 = 0;
    int outs4 = 0, outs8 = 0, outs2 = 0;
    logic prev4 = 1'b0, prev8 = 1'b0, prev2 = 1'b0;

    bf16_reduce_sum #(.N_OPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .operands(ops4), .in_STB(stb4),
`ifdef BF16_REDUCE_ACC_EN
        .acc_clr(clr4),
`endif
        .in_BUSY(busy4), .result(res4), .out_STB(ostb4), .out_module_BUSY(obusy4));

    bf16_reduce_sum #(.N_OPS(8)) u_dut8 (
        .clk(clk), .rst(rst), .operands(ops8), .in_STB(stb8),
`ifdef BF16_REDUCE_ACC_EN
        .acc_clr(clr8),
`endif
        .in_BUSY(busy8), .result(res8), .out_STB(ostb8), .out_module_BUSY(obusy8));

    bf16_reduce_sum #(.N_OPS(2)) u_dut2 (
        .clk(clk), .rst(rst), .operands(ops2), .in_STB(stb2),
`ifdef BF16_REDUCE_ACC_EN
        .acc_clr(clr2),
`endif
        .in_BUSY(busy2), .result(res2), .out_STB(ostb2), .out_module_BUSY(obusy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Adder handshakes (acceptance cycles) per instance
    always @(posedge clk) begin
        if (u_dut4.r_add_stb && !u_dut4.w_add_busy) adds4++;
        if (u_dut8.r_add_stb && !u_dut8.w_add_busy) adds8++;
        if (u_dut2.r_add_stb && !u_dut2.w_add_busy) adds2++;
    end

    // Scoreboard drain on each new result
    always @(negedge clk) begin
        logic [31:0] e;
        if (ostb4 && !prev4) begin
            outs4++;
            e = (q4.size() != 0) ? {16'h0000, q4.pop_front()} : 32'hDEADBEEF;
            check_val("res4", {16'h0000, res4}, e);
        end
        if (ostb8 && !prev8) begin
            outs8++;
            e = (q8.size() != 0) ? {16'h0000, q8.pop_front()} : 32'hDEADBEEF;
            check_val("res8", {16'h0000, res8}, e);
        end
        if (ostb2 && !prev2) begin
            outs2++;
            e = (q2.size() != 0) ? {16'h0000, q2.pop_front()} : 32'hDEADBEEF;
            check_val("res2", {16'h0000, res2}, e);
        end
        prev4 = ostb4;
        prev8 = ostb8;
        prev2 = ostb2;
    end

    function automatic logic get_ostb(input int sel);
        case (sel)
            4: return ostb4;
            8: return ostb8;
            2: return ostb2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            4: return busy4;
            8: return busy8;
            2: return busy2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int get_adds(input int sel);
        case (sel)
            4: return adds4;
            8: return adds8;
            2: return adds2;
            default: return 0;
        endcase
    endfunction

    // Drive one vector, push expected result, check latency and adder use
    task automatic run_vec(input int sel, input logic [127:0] ops, input logic [15:0] exp_res,
                           input logic clr, input string tag);
        int lat;
        int a0;
        int n_add;
        n_add = sel - 1 + ACC_ADD;
        @(negedge clk);
        a0 = get_adds(sel);
        case (sel)
            4: begin ops4 = ops[63:0]; clr4 = clr; stb4 = 1'b1; q4.push_back(exp_res); end
            8: begin ops8 = ops;       clr8 = clr; stb8 = 1'b1; q8.push_back(exp_res); end
            2: begin ops2 = ops[31:0]; clr2 = clr; stb2 = 1'b1; q2.push_back(exp_res); end
            default: ;
        endcase
        @(negedge clk);
        stb4 = 1'b0; stb8 = 1'b0; stb2 = 1'b0;
        lat = 0;
        while (!get_ostb(sel) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'(3 * n_add));
        check_val({tag, "_adds"}, 32'(get_adds(sel) - a0), 32'(n_add));
    endtask

    task automatic wait_idle(input int sel, input string tag);
        int n;
        n = 0;
        while (get_busy(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_idle"}, {31'h0, get_busy(sel)}, 32'h0);
    endtask

    initial begin
        int a0;
        int n;
        int o8;
        rst = 1'b0;
        ops4 = '0; ops8 = '0; ops2 = '0;
        stb4 = 1'b0; stb8 = 1'b0; stb2 = 1'b0;
        clr4 = 1'b1; clr8 = 1'b1; clr2 = 1'b1;
        obusy4 = 1'b0; obusy8 = 1'b0; obusy2 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_busy", {31'h0, busy4}, 32'h0);
        check_val("rst_out_stb", {31'h0, ostb4}, 32'h0);
        check_val("rst_result", {16'h0, res4}, 32'h0);
        rst = 1'b1;

        // 1+2+3+4 = 10
        run_vec(4, {64'h0, 16'h4080, 16'h4040, 16'h4000, 16'h3F80}, 16'h4120, 1'b1, "sum4");
        wait_idle(4, "sum4");
        check_val("sum4_outs", 32'(outs4), 32'd1);

        // Reset during the second addition's WAIT aborts the vector
        @(negedge clk);
        a0 = adds4;
        ops4 = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
        stb4 = 1'b1;
        @(negedge clk);
        stb4 = 1'b0;
        n = 0;
        while ((adds4 - a0) < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_reach", 32'(adds4 - a0), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_in_busy", {31'h0, busy4}, 32'h0);
        check_val("abort_out_stb", {31'h0, ostb4}, 32'h0);
        check_val("abort_result", {16'h0, res4}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_vec(4, {64'h0, {4{16'h4000}}}, 16'h4100, 1'b1, "after_rst");
        wait_idle(4, "after_rst");

        // (1-1)+(2-2) = +0
        run_vec(4, {64'h0, 16'hC000, 16'h4000, 16'hBF80, 16'h3F80}, 16'h0000, 1'b1, "cancel4");
        wait_idle(4, "cancel4");

        // Eight ones with downstream back-pressure and an ignored in_STB
        o8 = outs8;
        obusy8 = 1'b1;
        run_vec(8, {8{16'h3F80}}, 16'h4100, 1'b1, "sum8");
        for (int k = 0; k < 5; k++) begin
            check_val("hold_out_stb", {31'h0, ostb8}, 32'h1);
            check_val("hold_result", {16'h0, res8}, 32'h4100);
            check_val("hold_in_busy", {31'h0, busy8}, 32'h1);
            if (k == 1) begin
                ops8 = {8{16'h4000}};
                stb8 = 1'b1;
            end else begin
                stb8 = 1'b0;
            end
            @(negedge clk);
        end
        stb8 = 1'b0;
        obusy8 = 1'b0;
        wait_idle(8, "sum8");
        repeat (40) @(negedge clk);
        check_val("sum8_outs", 32'(outs8 - o8), 32'd1);
        check_val("sum8_still_idle", {31'h0, busy8}, 32'h0);

        // N_OPS=2: 0.5+0.5 = 1.0
        run_vec(2, {96'h0, 16'h3F00, 16'h3F00}, 16'h3F80, 1'b1, "sum2");
        wait_idle(2, "sum2");

`ifdef BF16_REDUCE_ACC_EN
        run_vec(4, {64'h0, {4{16'h3F80}}}, 16'h4080, 1'b1, "acc_clr1");
        wait_idle(4, "acc_clr1");
        run_vec(4, {64'h0, {4{16'h3F80}}}, 16'h4100, 1'b0, "acc_keep");
        wait_idle(4, "acc_keep");
        run_vec(4, {64'h0, {4{16'h3F80}}}, 16'h4080, 1'b1, "acc_clr2");
        wait_idle(4, "acc_clr2");
`endif

        repeat (5) @(negedge clk);
        check_val("q4_empty", 32'(q4.size()), 32'd0);
        check_val("q8_empty", 32'(q8.size()), 32'd0);
        check_val("q2_empty", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
